// File: rtl/sr_ff_monitor.sv
// Receive-side checker for an SR flip-flop: runs a golden SR model delayed by LAT edges,
// compares the snooped Q/Q_bar against it, and keeps saturating check/error/illegal counters.
module sr_ff_monitor #(
  parameter int CNT_W       = 8,
  parameter int LAT         = 1,
  parameter int STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             S,
  input  logic             R,
  input  logic             Q,
  input  logic             Q_bar,
  output logic [CNT_W-1:0] check_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic             err,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t           state, state_nx;
  logic             q_m, k_m;
  logic             q_e, k_e;
  logic             mismatch;
  logic [CNT_W-1:0] check_nx, err_cnt_nx, illegal_nx, first_nx;
  logic             err_nx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Golden model: k_m marks whether q_m is defined (S=R=1 makes it unknown).
  always_ff @(posedge clk) begin
    if (rst) begin
      q_m <= 1'b0;
      k_m <= 1'b0;
    end else begin
      case ({S, R})
        2'b01:   begin q_m <= 1'b0; k_m <= 1'b1; end
        2'b10:   begin q_m <= 1'b1; k_m <= 1'b1; end
        2'b11:   k_m <= 1'b0;
        default: ;
      endcase
    end
  end

  // LAT-1 extra stages align the model with the DUT output latency.
  generate
    if (LAT == 1) begin : g_nopipe
      assign q_e = q_m;
      assign k_e = k_m;
    end else begin : g_pipe
      logic [LAT-2:0] q_pipe, k_pipe;
      always_ff @(posedge clk) begin
        if (rst) begin
          q_pipe <= '0;
          k_pipe <= '0;
        end else begin
          q_pipe[0] <= q_m;
          k_pipe[0] <= k_m;
          for (int unsigned i = 1; i < LAT - 1; i++) begin
            q_pipe[i] <= q_pipe[i-1];
            k_pipe[i] <= k_pipe[i-1];
          end
        end
      end
      assign q_e = q_pipe[LAT-2];
      assign k_e = k_pipe[LAT-2];
    end
  endgenerate

  assign mismatch = k_e & ((Q != q_e) | (Q_bar == Q));

  always_comb begin
    state_nx   = state;
    check_nx   = check_cnt;
    err_cnt_nx = err_cnt;
    illegal_nx = illegal_cnt;
    first_nx   = first_err_idx;
    err_nx     = err;
    if (clr) begin
      state_nx   = IDLE;
      check_nx   = '0;
      err_cnt_nx = '0;
      illegal_nx = '0;
      first_nx   = '0;
      err_nx     = 1'b0;
    end else begin
      case (state)
        IDLE: if (en) state_nx = RUN;
        RUN: begin
          if (S & R) illegal_nx = sat_inc(illegal_cnt);
          if (k_e) check_nx = sat_inc(check_cnt);
          if (mismatch) begin
            err_cnt_nx = sat_inc(err_cnt);
            err_nx     = 1'b1;
            if (!err) first_nx = check_cnt;
          end
          if (mismatch && (STOP_ON_ERR != 0)) state_nx = HALT;
          else if (!en)                       state_nx = IDLE;
        end
        HALT: ;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      check_cnt     <= '0;
      err_cnt       <= '0;
      illegal_cnt   <= '0;
      first_err_idx <= '0;
      err           <= 1'b0;
    end else begin
      state         <= state_nx;
      check_cnt     <= check_nx;
      err_cnt       <= err_cnt_nx;
      illegal_cnt   <= illegal_nx;
      first_err_idx <= first_nx;
      err           <= err_nx;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_sr_ff_monitor.sv
// Bench for sr_ff_monitor: directed vector table, hand-written corner sequences, and
// randomized traffic checked against a history-based reference of the monitor rules.
module tb_sr_ff_monitor;

  logic clk = 1'b0;
  logic rst, en, clr, S, R, Q, Q_bar;

  logic [7:0] d_chk, d_err, d_ill, d_fidx;  logic d_e, d_busy;
  logic [7:0] h_chk, h_err, h_ill, h_fidx;  logic h_e, h_busy;
  logic [1:0] s_chk, s_err, s_ill, s_fidx;  logic s_e, s_busy;
  logic [2:0] r_chk, r_err, r_ill, r_fidx;  logic r_e, r_busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sr_ff_monitor #(.CNT_W(8), .LAT(1), .STOP_ON_ERR(0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .S(S), .R(R), .Q(Q), .Q_bar(Q_bar),
    .check_cnt(d_chk), .err_cnt(d_err), .illegal_cnt(d_ill), .err(d_e),
    .first_err_idx(d_fidx), .busy(d_busy));
  sr_ff_monitor #(.CNT_W(8), .LAT(1), .STOP_ON_ERR(1)) u_halt (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .S(S), .R(R), .Q(Q), .Q_bar(Q_bar),
    .check_cnt(h_chk), .err_cnt(h_err), .illegal_cnt(h_ill), .err(h_e),
    .first_err_idx(h_fidx), .busy(h_busy));
  sr_ff_monitor #(.CNT_W(2), .LAT(1), .STOP_ON_ERR(0)) u_sat (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .S(S), .R(R), .Q(Q), .Q_bar(Q_bar),
    .check_cnt(s_chk), .err_cnt(s_err), .illegal_cnt(s_ill), .err(s_e),
    .first_err_idx(s_fidx), .busy(s_busy));
  sr_ff_monitor #(.CNT_W(3), .LAT(3), .STOP_ON_ERR(1)) u_rnd (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .S(S), .R(R), .Q(Q), .Q_bar(Q_bar),
    .check_cnt(r_chk), .err_cnt(r_err), .illegal_cnt(r_ill), .err(r_e),
    .first_err_idx(r_fidx), .busy(r_busy));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic r, input logic q, input logic qb);
    S = s; R = r; Q = q; Q_bar = qb;
  endtask

  // Directed vectors: inputs before the edge, expected outputs after it.
  typedef struct {
    logic s, r, q, qb;
    int   chk, err, ill;
    int   hchk, herr, hill;
    logic hbusy;
  } vec_t;
  vec_t tv[18];

  // Reference: model state rebuilt from the S/R history since reset.
  typedef struct { int st; int chk, err, ill, fidx; bit e; } mref_t;
  mref_t m[2];
  int    m_lat[2] = '{1, 3};
  int    m_stp[2] = '{0, 1};
  int    m_max[2] = '{255, 7};
  int    hs[$];

  function automatic void known_at(input int lat, output bit k, output bit q);
    k = 1'b0;
    q = 1'b0;
    for (int i = hs.size() - lat; i >= 0; i--) begin
      if (hs[i] != 0) begin
        k = (hs[i] != 3);
        q = (hs[i] == 2);
        break;
      end
    end
  endfunction

  function automatic int inc_sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_edge();
    bit k, q, mm;
    int old;
    if (rst) begin
      for (int i = 0; i < 2; i++) m[i] = '{0, 0, 0, 0, 0, 1'b0};
      hs.delete();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      known_at(m_lat[i], k, q);
      if (clr) m[i] = '{0, 0, 0, 0, 0, 1'b0};
      else if (m[i].st == 0) begin
        if (en) m[i].st = 1;
      end else if (m[i].st == 1) begin
        if (S && R) m[i].ill = inc_sat(m[i].ill, m_max[i]);
        mm  = k && ((Q != q) || (Q_bar == Q));
        old = m[i].chk;
        if (k) m[i].chk = inc_sat(m[i].chk, m_max[i]);
        if (mm) begin
          if (!m[i].e) m[i].fidx = old;
          m[i].err = inc_sat(m[i].err, m_max[i]);
          m[i].e   = 1'b1;
        end
        if (mm && m_stp[i] != 0) m[i].st = 2;
        else if (!en)            m[i].st = 0;
      end
    end
    hs.push_back({S, R});
  endtask

  initial begin
    bit kk, qq;
    rst = 1'b1; en = 1'b0; clr = 1'b0;
    drive(0, 0, 0, 1);

    tv[0]  = '{0,0,0,1, 0,0,0, 0,0,0, 1'b1};
    tv[1]  = '{0,1,0,1, 0,0,0, 0,0,0, 1'b1};
    tv[2]  = '{1,0,0,1, 1,0,0, 1,0,0, 1'b1};
    tv[3]  = '{1,1,1,0, 2,0,1, 2,0,1, 1'b1};
    tv[4]  = '{0,0,1,0, 2,0,1, 2,0,1, 1'b1};
    tv[5]  = '{1,1,1,1, 2,0,2, 2,0,2, 1'b1};
    tv[6]  = '{1,0,0,0, 2,0,2, 2,0,2, 1'b1};
    tv[7]  = '{0,1,1,0, 3,0,2, 3,0,2, 1'b1};
    tv[8]  = '{0,1,0,1, 4,0,2, 4,0,2, 1'b1};
    tv[9]  = '{0,0,0,1, 0,0,0, 0,0,0, 1'b1};
    tv[10] = '{0,1,0,1, 0,0,0, 0,0,0, 1'b1};
    tv[11] = '{1,0,0,1, 1,0,0, 1,0,0, 1'b1};
    tv[12] = '{1,1,0,1, 2,1,1, 2,1,1, 1'b0};
    tv[13] = '{0,0,0,1, 2,1,1, 2,1,1, 1'b0};
    tv[14] = '{1,1,0,1, 2,1,2, 2,1,1, 1'b0};
    tv[15] = '{1,0,0,1, 2,1,2, 2,1,1, 1'b0};
    tv[16] = '{0,1,0,1, 3,2,2, 2,1,1, 1'b0};
    tv[17] = '{0,1,0,1, 4,2,2, 2,1,1, 1'b0};

    tick();
    chk("reset check_cnt", d_chk, 0);
    chk("reset err_cnt", d_err, 0);
    chk("reset illegal_cnt", d_ill, 0);
    chk("reset err", d_e, 0);
    chk("reset first_err_idx", d_fidx, 0);
    chk("reset busy", d_busy, 0);

    // Correct DUT (rows 0-8), then Q stuck at 0 (rows 9-17), each after a reset.
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i == 9) begin
        chk("t1 err flag", d_e, 0);
        rst = 1'b1; tick(); rst = 1'b0;
      end
      drive(tv[i].s, tv[i].r, tv[i].q, tv[i].qb);
      tick();
      chk($sformatf("vec%0d check_cnt", i), d_chk, tv[i].chk);
      chk($sformatf("vec%0d err_cnt", i), d_err, tv[i].err);
      chk($sformatf("vec%0d illegal_cnt", i), d_ill, tv[i].ill);
      chk($sformatf("vec%0d busy", i), d_busy, 1);
      chk($sformatf("vec%0d halt check_cnt", i), h_chk, tv[i].hchk);
      chk($sformatf("vec%0d halt err_cnt", i), h_err, tv[i].herr);
      chk($sformatf("vec%0d halt illegal_cnt", i), h_ill, tv[i].hill);
      chk($sformatf("vec%0d halt busy", i), h_busy, tv[i].hbusy);
    end
    chk("t2 err flag", d_e, 1);
    chk("t2 first_err_idx", d_fidx, 1);
    chk("t3 halt err flag", h_e, 1);
    chk("t3 halt first_err_idx", h_fidx, 1);

    // Q_bar equal to Q: every check fails; CNT_W=2 instance saturates.
    rst = 1'b1; tick(); rst = 1'b0;
    drive(1, 0, 1, 1);
    for (int i = 0; i < 6; i++) tick();
    chk("t4 check_cnt", d_chk, 5);
    chk("t4 err_cnt", d_err, 5);
    chk("t4 first_err_idx", d_fidx, 0);
    chk("t5 sat check_cnt", s_chk, 3);
    chk("t5 sat err_cnt", s_err, 3);
    chk("t5 sat illegal_cnt", s_ill, 0);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t5 clr check_cnt", d_chk, 0);
    chk("t5 clr err_cnt", d_err, 0);
    chk("t5 clr err", d_e, 0);
    chk("t5 clr busy", d_busy, 0);
    chk("t5 clr sat check_cnt", s_chk, 0);
    chk("t5 clr sat err_cnt", s_err, 0);
    chk("t5 clr sat err", s_e, 0);
    chk("t5 clr sat first_err_idx", s_fidx, 0);
    chk("t5 clr sat busy", s_busy, 0);
    chk("t5 clr halt check_cnt", h_chk, 0);

    // Reset mid-run wipes the model too: no check until a fresh set plus one edge.
    drive(1, 0, 1, 0);
    tick(); tick();
    chk("t6 pre-rst check_cnt", d_chk, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6 rst check_cnt", d_chk, 0);
    chk("t6 rst busy", d_busy, 0);
    drive(0, 0, 0, 0);
    tick(); tick();
    chk("t6 no check after rst", d_chk, 0);
    chk("t6 no err after rst", d_err, 0);
    drive(1, 0, 0, 0);
    tick();
    chk("t6 set edge check_cnt", d_chk, 0);
    drive(0, 0, 1, 0);
    tick();
    chk("t6 first check", d_chk, 1);
    chk("t6 first check err", d_err, 0);

    // Randomized traffic against the reference.
    rst = 1'b1; tick(); model_edge(); rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom % 100) == 0;
      clr = ($urandom % 30) == 0;
      en  = ($urandom % 8) != 0;
      S   = $urandom % 2;
      R   = $urandom % 2;
      known_at(3, kk, qq);
      if (kk && ($urandom % 5) != 0) begin
        Q = qq; Q_bar = ~qq;
      end else begin
        Q = $urandom % 2; Q_bar = $urandom % 2;
      end
      tick();
      model_edge();
      chk("rnd check_cnt", d_chk, m[0].chk);
      chk("rnd err_cnt", d_err, m[0].err);
      chk("rnd illegal_cnt", d_ill, m[0].ill);
      chk("rnd first_err_idx", d_fidx, m[0].fidx);
      chk("rnd err", d_e, m[0].e);
      chk("rnd busy", d_busy, m[0].st == 1);
      chk("rnd lat3 check_cnt", r_chk, m[1].chk);
      chk("rnd lat3 err_cnt", r_err, m[1].err);
      chk("rnd lat3 illegal_cnt", r_ill, m[1].ill);
      chk("rnd lat3 first_err_idx", r_fidx, m[1].fidx);
      chk("rnd lat3 err", r_e, m[1].e);
      chk("rnd lat3 busy", r_busy, m[1].st == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
